dual_rr_arbiter: RTL and testbench

//   Shares two identical resource slots (slot 0, slot 1) between N requesters.
//   Up to two grants are issued per cycle using rotating (round-robin) priority.

---
 rtl/dual_rr_arbiter_pkg.sv | 16 +
 rtl/dual_rr_arbiter_pick.sv | 36 +++
 rtl/dual_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_dual_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dual_rr_arbiter_pkg.sv
// Shared types and helpers for the dual-slot round-robin arbiter.
package dual_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_state_t;

    localparam int NUM_SLOTS = 2;

    // Rotating index: (base + offs) wrapped into 0..n-1.
    function automatic int rot_idx(input int base, input int offs, input int n);
        return (base + offs) % n;
    endfunction

endpackage

// File: rtl/dual_rr_arbiter_pick.sv
// Combinational scan of a request vector from a rotating start index,
// returning the first two set positions in priority order.
module rr_dual_pick
    import dual_arb_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   vec_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] first_id_o,
    output logic           first_found_o,
    output logic [IDW-1:0] second_id_o,
    output logic           second_found_o
);

    always_comb begin
        first_id_o     = '0;
        first_found_o  = 1'b0;
        second_id_o    = '0;
        second_found_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = rot_idx(int'(ptr_i), i, N);
            if (vec_i[idx] && !first_found_o) begin
                first_found_o = 1'b1;
                first_id_o    = IDW'(idx);
            end else if (vec_i[idx] && !second_found_o) begin
                second_found_o = 1'b1;
                second_id_o    = IDW'(idx);
            end else begin
            end
        end
    end

endmodule

// File: rtl/dual_rr_arbiter.sv
// Two-slot round-robin arbiter: each slot is held until done or a hold
// timeout; all outputs come straight from registers.
module dual_rr_arbiter
    import dual_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 15,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           done0,
    input  logic           done1,
    output logic           gnt0_valid,
    output logic [IDW-1:0] gnt0_id,
    output logic           gnt1_valid,
    output logic [IDW-1:0] gnt1_id,
    output logic [N-1:0]   gnt_vec,
    output logic [1:0]     timeout
);

    localparam int             CW        = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    slot_state_t    state_q [NUM_SLOTS];
    slot_state_t    state_d [NUM_SLOTS];
    logic [IDW-1:0] id_q    [NUM_SLOTS];
    logic [IDW-1:0] id_d    [NUM_SLOTS];
    logic [CW-1:0]  cnt_q   [NUM_SLOTS];
    logic [CW-1:0]  cnt_d   [NUM_SLOTS];
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   vec_q, vec_d;
    logic [1:0]     tmo_q, tmo_d;

    logic [N-1:0]   elig_s;
    logic [1:0]     done_s;
    logic [IDW-1:0] first_id_s, second_id_s;
    logic           first_found_s, second_found_s;

    // Current owners are excluded so no requester can hold both slots.
    assign elig_s = req & ~vec_q;
    assign done_s = {done1, done0};

    rr_dual_pick #(.N(N)) u_pick (
        .vec_i          (elig_s),
        .ptr_i          (ptr_q),
        .first_id_o     (first_id_s),
        .first_found_o  (first_found_s),
        .second_id_o    (second_id_s),
        .second_found_o (second_found_s)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        tmo_d   = 2'b00;
        vec_d   = '0;

        // Release first; a slot busy this cycle is never handed out this cycle.
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (state_q[k] == BUSY) begin
                if (done_s[k]) begin
                    state_d[k] = IDLE;
                end else if (cnt_q[k] == HOLD_LAST) begin
                    state_d[k] = IDLE;
                    tmo_d[k]   = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else begin
            end
        end

        if ((state_q[0] == IDLE) && first_found_s) begin
            state_d[0] = BUSY;
            id_d[0]    = first_id_s;
            cnt_d[0]   = '0;
            if ((state_q[1] == IDLE) && second_found_s) begin
                state_d[1] = BUSY;
                id_d[1]    = second_id_s;
                cnt_d[1]   = '0;
                ptr_d      = IDW'(rot_idx(int'(second_id_s), 1, N));
            end else begin
                ptr_d = IDW'(rot_idx(int'(first_id_s), 1, N));
            end
        end else if ((state_q[1] == IDLE) && first_found_s) begin
            state_d[1] = BUSY;
            id_d[1]    = first_id_s;
            cnt_d[1]   = '0;
            ptr_d      = IDW'(rot_idx(int'(first_id_s), 1, N));
        end else begin
        end

        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (state_d[k] == BUSY) begin
                vec_d[id_d[k]] = 1'b1;
            end else begin
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                state_q[k] <= IDLE;
                id_q[k]    <= '0;
                cnt_q[k]   <= '0;
            end
            ptr_q <= '0;
            vec_q <= '0;
            tmo_q <= 2'b00;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                state_q[k] <= state_d[k];
                id_q[k]    <= id_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            ptr_q <= ptr_d;
            vec_q <= vec_d;
            tmo_q <= tmo_d;
        end
    end

    assign gnt0_valid = (state_q[0] == BUSY);
    assign gnt1_valid = (state_q[1] == BUSY);
    assign gnt0_id    = id_q[0];
    assign gnt1_id    = id_q[1];
    assign gnt_vec    = vec_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_dual_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the dual-slot arbiter.
module tb_dual_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 3;
    localparam int IDW      = $clog2(N);

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic           done0, done1;
    logic           gnt0_valid, gnt1_valid;
    logic [IDW-1:0] gnt0_id, gnt1_id;
    logic [N-1:0]   gnt_vec;
    logic [1:0]     timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit         m_busy  [2];
    int         m_owner [2];
    int         m_age   [2];
    int         m_ptr;
    logic [1:0] m_tmo;

    dual_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done0      (done0),
        .done1      (done1),
        .gnt0_valid (gnt0_valid),
        .gnt0_id    (gnt0_id),
        .gnt1_valid (gnt1_valid),
        .gnt1_id    (gnt1_id),
        .gnt_vec    (gnt_vec),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k]  = 1'b0;
            m_owner[k] = 0;
            m_age[k]   = 0;
        end
        m_ptr = 0;
        m_tmo = 2'b00;
    endtask

    function automatic logic [N-1:0] model_vec();
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < 2; k++)
            if (m_busy[k]) v[m_owner[k]] = 1'b1;
        return v;
    endfunction

    // One clock edge of the arbiter, expressed as the rules in plain words:
    // release on done or after MAX_HOLD visible cycles, then hand eligible
    // requesters (in rotating order from ptr) to slots that were idle.
    task automatic model_step();
        bit was_busy [2];
        bit owned    [N];
        bit dn       [2];
        int hits[$];
        int free_slots[$];
        if (reset) begin
            model_reset();
            return;
        end
        dn[0] = done0;
        dn[1] = done1;
        m_tmo = 2'b00;
        for (int i = 0; i < N; i++) owned[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            was_busy[k] = m_busy[k];
            if (m_busy[k]) owned[m_owner[k]] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (was_busy[k]) begin
                if (dn[k]) m_busy[k] = 1'b0;
                else if (m_age[k] == MAX_HOLD) begin
                    m_busy[k] = 1'b0;
                    m_tmo[k]  = 1'b1;
                end else m_age[k]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (m_ptr + i) % N;
            if (req[idx] && !owned[idx]) hits.push_back(idx);
        end
        for (int k = 0; k < 2; k++)
            if (!was_busy[k]) free_slots.push_back(k);
        if (hits.size() > 0 && free_slots.size() > 0) begin
            int last;
            m_busy[free_slots[0]]  = 1'b1;
            m_owner[free_slots[0]] = hits[0];
            m_age[free_slots[0]]   = 1;
            last = hits[0];
            if (free_slots.size() == 2 && hits.size() > 1) begin
                m_busy[1]  = 1'b1;
                m_owner[1] = hits[1];
                m_age[1]   = 1;
                last = hits[1];
            end
            m_ptr = (last + 1) % N;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = '0;
        done0 = 1'b0;
        done1 = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Continuous comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        check("gnt0_valid", 32'(gnt0_valid), 32'(m_busy[0]));
        check("gnt1_valid", 32'(gnt1_valid), 32'(m_busy[1]));
        if (m_busy[0]) check("gnt0_id", 32'(gnt0_id), 32'(m_owner[0]));
        if (m_busy[1]) check("gnt1_id", 32'(gnt1_id), 32'(m_owner[1]));
        check("gnt_vec", 32'(gnt_vec), 32'(model_vec()));
        check("timeout", 32'(timeout), 32'(m_tmo));
    end

    initial begin
        int cnt [N];
        int total;
        reset = 1'b1;
        req   = '0;
        done0 = 1'b0;
        done1 = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) tick();
        check("rst_valid0", 32'(gnt0_valid), 32'd0);
        check("rst_valid1", 32'(gnt1_valid), 32'd0);
        check("rst_ids", 32'({gnt0_id, gnt1_id}), 32'd0);
        check("rst_vec", 32'(gnt_vec), 32'd0);
        check("rst_tmo", 32'(timeout), 32'd0);

        // Two grants in one cycle
        req = 4'b1010;
        tick();
        check("dual_id0", 32'(gnt0_id), 32'd1);
        check("dual_id1", 32'(gnt1_id), 32'd3);
        check("dual_valid", 32'({gnt0_valid, gnt1_valid}), 32'd3);
        check("dual_vec", 32'(gnt_vec), 32'hA);
        check("dual_ptr_model", 32'(m_ptr), 32'd0);

        // Single free slot, rotating start, timeout overlapping a new grant
        do_reset();
        req = 4'b0010;
        tick();
        check("s3_id0", 32'(gnt0_id), 32'd1);
        check("s3_valid1", 32'(gnt1_valid), 32'd0);
        check("s3_ptr_model", 32'(m_ptr), 32'd2);
        req = 4'b1111;
        tick();
        check("s3_id1", 32'(gnt1_id), 32'd2);
        check("s3_ptr3_model", 32'(m_ptr), 32'd3);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        check("s3_rel1", 32'(gnt1_valid), 32'd0);
        tick();
        check("s3_tmo", 32'(timeout), 32'd1);
        check("s3_v0_fall", 32'(gnt0_valid), 32'd0);
        check("s3_id1_next", 32'(gnt1_id), 32'd3);
        check("s3_vec", 32'(gnt_vec), 32'h8);
        tick();
        check("s3_id0_next", 32'(gnt0_id), 32'd0);
        check("s3_vec2", 32'(gnt_vec), 32'h9);
        check("s3_tmo_clr", 32'(timeout), 32'd0);

        // Hold timeout with request dropped
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("to_c1", 32'(gnt0_valid), 32'd1);
        tick();
        check("to_c2", 32'(gnt0_valid), 32'd1);
        tick();
        check("to_c3", 32'(gnt0_valid), 32'd1);
        check("to_c3_tmo", 32'(timeout), 32'd0);
        tick();
        check("to_fall", 32'(gnt0_valid), 32'd0);
        check("to_pulse", 32'(timeout), 32'd1);
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        check("to_pulse_end", 32'(timeout), 32'd0);

        // done coinciding with the timeout cycle wins
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        tick();
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        check("dt_fall", 32'(gnt0_valid), 32'd0);
        check("dt_no_tmo", 32'(timeout), 32'd0);

        // Fairness with all requesters active
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        total = 0;
        req = 4'b1111;
        for (int c = 0; c < 40 && total < 8; c++) begin
            tick();
            done0 = gnt0_valid;
            done1 = gnt1_valid;
            if (gnt0_valid) begin cnt[gnt0_id]++; total++; end
            if (gnt1_valid) begin cnt[gnt1_id]++; total++; end
        end
        req = '0;
        tick();
        done0 = 1'b0;
        done1 = 1'b0;
        check("fair_total", 32'(total), 32'd8);
        for (int i = 0; i < N; i++) check("fair_count", 32'(cnt[i]), 32'd2);

        // Asynchronous reset while both slots are busy
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("ar_valid", 32'({gnt0_valid, gnt1_valid}), 32'd0);
        check("ar_vec", 32'(gnt_vec), 32'd0);
        check("ar_ids", 32'({gnt0_id, gnt1_id}), 32'd0);
        check("ar_tmo", 32'(timeout), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_first0", 32'(gnt0_id), 32'd0);
        check("ar_first1", 32'(gnt1_id), 32'd1);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req   = 4'($urandom_range(0, 15));
            done0 = ($urandom_range(0, 3) == 0);
            done1 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
